// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out deserializer. Collects DATA_WIDTH serial bits
// (LSB first) into a word and presents it on a valid/ready output port. It
// directly consumes the bit-0-first stream of the team's parallel-in
// serial-out stage.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   resetn     : asynchronous active-low reset (release synchronized upstream)
//   din        : serial data bit, LSB first
//   din_valid  : din is sampled only when this is 1
//   din_first  : current bit is bit 0 of a new word (qualified by din_valid)
//   dout       : assembled parallel word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout when dout_valid && dout_ready
//   overflow   : sticky, a completed word was dropped (cleared only by reset)
// ---------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  din_first,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow
);

    localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(0);
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] dout_q,  dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q,   overflow_d;

    logic                  complete_s;
    logic                  handshake_s;

    // A word completes on an accepted bit at the last count, unless that bit
    // restarts framing with din_first (restart wins, nothing completes).
    assign complete_s  = din_valid && !din_first && (cnt_q == CNT_LAST);
    assign handshake_s = dout_valid_q && dout_ready;

    // Bit counter next state: restart, wrap on completion, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (din_valid) begin
            if (din_first) begin
                cnt_d = CNT_ONE;
            end else if (complete_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Assembly register next state: bits enter at the MSB and shift right so
    // the first bit of a word ends up at bit 0 after DATA_WIDTH shifts.
    always_comb begin
        shift_d = shift_q;
        if (din_valid) begin
            if (din_first) begin
                shift_d = {din, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                shift_d = {din, shift_q[DATA_WIDTH-1:1]};
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // Output register next state: load on completion if the slot is free or
    // being drained this edge, otherwise drop the word and flag overflow.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        if (complete_s) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_d;
                dout_valid_d = 1'b1;
            end else begin
                overflow_d   = 1'b1;
            end
        end else if (handshake_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // Bit counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Assembly shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= WORD_ZERO;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Output word, valid flag and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q       <= WORD_ZERO;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

endmodule
